serial_adc_capture: RTL
=======================

SERIAL_ADC_CAPTURE -- requirements
Module: serial_adc_capture

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, bits per conversion word (range 8..32).
REQ-002 SHALL have parameter NUM_CH, default 2, daisy-chained words per frame (range 1..8).
REQ-003 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk period (even, >=2).
REQ-004 SHALL have parameter START_LEN, default 4, start pulse width in clk cycles (>=1).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65535, drdy wait limit in clk cycles.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 measure  in  1  single-cycle request to begin a conversion.
REQ-009 continuous  in  1  1 = keep capturing frames without new start pulses; sampled at each frame end.
REQ-010 drdy_n  in  1  asynchronous ADC data-ready, active-low.
REQ-011 sdata  in  1  serial data from ADC, MSB first.
REQ-012 start  out  1  ADC start pulse.
REQ-013 sclk  out  1  serial clock to ADC, idle low.
REQ-014 data_out  out  DATA_WIDTH  captured word.
REQ-015 data_ch  out  max(1,$clog2(NUM_CH))  channel index of data_out.
REQ-016 data_valid / data_ready  out / in  1  output handshake; word transfers when both are high.
REQ-017 busy  out  1  high in any state but IDLE.
REQ-018 overrun  out  1  sticky: a word was dropped.
REQ-019 timeout  out  1  sticky: drdy_n did not fall within TIMEOUT_CYCLES.

Function
REQ-020 drdy_n SHALL pass a 2-flop synchronizer; a falling edge on the synchronized signal SHALL be detected one clk later (3-cycle latency from pin).
REQ-021 FSM states SHALL be IDLE, START_PULSE, WAIT_DRDY, SHIFT, EMIT.
REQ-022 IDLE -> START_PULSE on measure; measure in any other state SHALL be ignored.
REQ-023 START_PULSE SHALL hold start=1 for exactly START_LEN cycles, then go to WAIT_DRDY.
REQ-024 WAIT_DRDY -> SHIFT on detected drdy_n falling edge; edges seen in any other state SHALL be ignored.
REQ-025 In SHIFT, sclk SHALL be low for CLK_DIV/2 cycles then high for CLK_DIV/2 cycles, repeating; first sclk rise CLK_DIV/2 cycles after SHIFT entry.
REQ-026 sdata SHALL be sampled on the clk edge where sclk falls and shifted in MSB first.
REQ-027 After DATA_WIDTH samples, the FSM SHALL enter EMIT for one cycle, load the word and channel index into the output register, then return to SHIFT for the next channel with sclk low.
REQ-028 After EMIT of channel NUM_CH-1: continuous=1 -> WAIT_DRDY; continuous=0 -> IDLE.
REQ-029 The output register SHALL be one-deep; data_valid SHALL stay high with data_out/data_ch stable until data_ready=1.
REQ-030 In EMIT, if data_valid=1 and data_ready=0, the new word SHALL be dropped, the register left unchanged, and overrun set; if data_ready=1 in that same cycle, the new word SHALL be loaded with no overrun.
REQ-031 overrun and timeout SHALL clear only on rst or on an accepted measure.

Reset
REQ-032 On rst: state IDLE, start=0, sclk=0, data_out=0, data_ch=0, data_valid=0, busy=0, overrun=0, timeout=0, bit and channel counters 0, synchronizer flops 1.
REQ-033 rst asserted mid-frame SHALL abort at once; the partial word SHALL be discarded and never presented.

Configuration
REQ-034 With macro SERIAL_ADC_TIMEOUT_EN defined, a counter SHALL run in WAIT_DRDY; after TIMEOUT_CYCLES cycles with no edge, timeout SHALL set and the FSM SHALL go to IDLE.
REQ-035 Without SERIAL_ADC_TIMEOUT_EN, WAIT_DRDY SHALL wait indefinitely, no counter SHALL be built, and timeout SHALL be tied 0.

Verification
REQ-036 DATA_WIDTH=24, NUM_CH=2, data_ready=1; measure; drdy_n falls; ADC sends 0xA5C3F1 then 0x123456 -> two words in order, data_ch 0 then 1, busy drops, overrun=0.
REQ-037 start pulse check: measure at cycle 10 -> start high for cycles 11..14 only (START_LEN=4); measure repeated at cycle 12 -> ignored.
REQ-038 data_ready=0 for the whole frame -> data_out holds 0xA5C3F1, ch 0; overrun=1 after the second EMIT.
REQ-039 continuous=1, three drdy_n falls -> six words ch 0,1,0,1,0,1 with exactly one start pulse; continuous=0 before the third frame ends -> IDLE after ch 1.
REQ-040 TIMEOUT_EN, TIMEOUT_CYCLES=100, no drdy_n -> timeout=1 and IDLE 100 cycles after WAIT_DRDY entry; without the macro, still busy at cycle 1000.
REQ-041 rst pulsed after 10 bits of channel 0 -> all outputs at reset values next cycle; a subsequent measure yields a correct full frame.

Source files
------------

// File: rtl/serial_adc_capture.sv
// Serial ADC capture: start pulse, drdy_n wait, daisy-chained word shift-in and a one-deep
// output register. Optional drdy_n timeout is enabled by defining SERIAL_ADC_TIMEOUT_EN.
module serial_adc_capture #(
  parameter int unsigned DATA_WIDTH     = 24,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned START_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          measure,
  input  logic                                          continuous,
  input  logic                                          drdy_n,
  input  logic                                          sdata,
  output logic                                          start,
  output logic                                          sclk,
  output logic [DATA_WIDTH-1:0]                         data_out,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] data_ch,
  output logic                                          data_valid,
  input  logic                                          data_ready,
  output logic                                          busy,
  output logic                                          overrun,
  output logic                                          timeout
);

  localparam int unsigned ChW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BitW    = $clog2(DATA_WIDTH);
  localparam int unsigned DivW    = $clog2(CLK_DIV);
  localparam int unsigned HalfDiv = CLK_DIV / 2;
  localparam int unsigned StartW  = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStartPulse,
    StWaitDrdy,
    StShift,
    StEmit
  } state_e;

  state_e                  state_q, state_d;
  logic                    start_q, start_d;
  logic                    sclk_q, sclk_d;
  logic [DivW-1:0]         div_q, div_d, div_nxt;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [ChW-1:0]          ch_q, ch_d;
  logic [StartW-1:0]       pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ChW-1:0]          data_ch_q, data_ch_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    sync3_q, sync3_d;
  logic                    drdy_fall;

`ifdef SERIAL_ADC_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0]          to_q, to_d;
  logic                    timeout_q, timeout_d;
`else
  logic                    unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // sync3 holds the previous synchronized level, so the fall pulse lasts one cycle
  assign drdy_fall = sync3_q & ~sync2_q;
  assign div_nxt   = (div_q == DivW'(CLK_DIV - 1)) ? '0 : div_q + DivW'(1);

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    sclk_d    = 1'b0;
    div_d     = div_q;
    bit_d     = bit_q;
    ch_d      = ch_q;
    pulse_d   = pulse_q;
    shift_d   = shift_q;
    data_d    = data_q;
    data_ch_d = data_ch_q;
    valid_d   = valid_q & ~data_ready;
    overrun_d = overrun_q;
    sync1_d   = drdy_n;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
`ifdef SERIAL_ADC_TIMEOUT_EN
    to_d      = to_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (measure) begin
          state_d   = StStartPulse;
          start_d   = 1'b1;
          pulse_d   = '0;
          overrun_d = 1'b0;
`ifdef SERIAL_ADC_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      StStartPulse: begin
        if (pulse_q == StartW'(START_LEN - 1)) begin
          state_d = StWaitDrdy;
`ifdef SERIAL_ADC_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          start_d = 1'b1;
          pulse_d = pulse_q + StartW'(1);
        end
      end
      StWaitDrdy: begin
        if (drdy_fall) begin
          state_d = StShift;
          div_d   = '0;
          bit_d   = '0;
          ch_d    = '0;
        end
`ifdef SERIAL_ADC_TIMEOUT_EN
        else if (to_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + ToW'(1);
        end
`endif
      end
      StShift: begin
        div_d  = div_nxt;
        sclk_d = (div_nxt >= DivW'(HalfDiv));
        // Last cycle of the high phase: sclk falls on this edge, so sample now
        if (div_q == DivW'(CLK_DIV - 1)) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sdata};
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
            state_d = StEmit;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      StEmit: begin
        if (!valid_q || data_ready) begin
          data_d    = shift_q;
          data_ch_d = ch_q;
          valid_d   = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        if (ch_q == ChW'(NUM_CH - 1)) begin
          ch_d    = '0;
          state_d = continuous ? StWaitDrdy : StIdle;
`ifdef SERIAL_ADC_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          ch_d    = ch_q + ChW'(1);
          div_d   = '0;
          state_d = StShift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      sclk_q    <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      ch_q      <= '0;
      pulse_q   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      data_ch_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync3_q   <= 1'b1;
`ifdef SERIAL_ADC_TIMEOUT_EN
      to_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      sclk_q    <= sclk_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      ch_q      <= ch_d;
      pulse_q   <= pulse_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
`ifdef SERIAL_ADC_TIMEOUT_EN
      to_q      <= to_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign start      = start_q;
  assign sclk       = sclk_q;
  assign data_out   = data_q;
  assign data_ch    = data_ch_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;
`ifdef SERIAL_ADC_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

endmodule
